// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - panel constants and prefetch FSM encoding shared with the LCD timing driver
package lcd_pkg;
   localparam int H_DISP = 480;
   localparam int V_DISP = 272;
   localparam int LEN_W  = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      DATA  = 2'd2,
      DRAIN = 2'd3
   } fetch_state_t;
endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock first-word-fall-through FIFO with synchronous flush
module sync_fifo #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 256
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   input  logic                   push,
   input  logic [DATA_W-1:0]      wr_data,
   input  logic                   pop,
   output logic [DATA_W-1:0]      rd_data,
   output logic [$clog2(DEPTH):0] count,
   output logic                   empty,
   output logic                   full
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic              do_push;
   logic              do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CNT_W'(DEPTH));
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         if (do_push && !do_pop)      count <= count + 1'b1;
         else if (do_pop && !do_push) count <= count - 1'b1;
      end
   end
endmodule

// File: rtl/lcd_frame_prefetch.sv
// rtl/lcd_frame_prefetch.sv - SDRAM burst prefetch feeding one pixel per LCD driver request
module lcd_frame_prefetch #(
   parameter int          DATA_W     = 16,
   parameter int          ADDR_W     = 22,
   parameter int          H_DISP     = lcd_pkg::H_DISP,
   parameter int          V_DISP     = lcd_pkg::V_DISP,
   parameter int unsigned BASE_ADDR  = 0,
   parameter int          BURST_LEN  = 64,
   parameter int          FIFO_DEPTH = 256
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     lcd_request,
   input  logic                     lcd_framesync,
   output logic [DATA_W-1:0]        lcd_data,
   output logic                     rd_req,
   output logic [ADDR_W-1:0]        rd_addr,
   output logic [lcd_pkg::LEN_W-1:0] rd_len,
   input  logic                     rd_ack,
   input  logic                     rd_valid,
   input  logic [DATA_W-1:0]        rd_data,
   output logic                     underflow
);
   import lcd_pkg::*;

   localparam int TOTAL = H_DISP * V_DISP;
   localparam int REM_W = $clog2(TOTAL) + 1;
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam logic [ADDR_W-1:0] BASE        = ADDR_W'(BASE_ADDR);
   localparam logic [REM_W-1:0]  FRAME_WORDS = REM_W'(TOTAL);

   fetch_state_t      state;
   fetch_state_t      state_nxt;
   logic              fs_s;
   logic              fs_d;
   logic              fs_evt;
   logic [ADDR_W-1:0] next_addr;
   logic [REM_W-1:0]  remaining;
   logic [LEN_W-1:0]  outstanding;
   logic [LEN_W-1:0]  len_calc;
   logic              stale;
   logic [CNT_W-1:0]  count;
   logic [31:0]       used;
   logic              room;
   logic              empty;
   logic              full;
   logic              beat;
   logic              last_beat;
   logic              push;
   logic              pop;
   logic [DATA_W-1:0] fifo_q;

   assign fs_evt    = fs_d && !fs_s;
   assign used      = 32'(count) + 32'(outstanding);
   assign room      = (32'(FIFO_DEPTH) - used) >= 32'(BURST_LEN);
   assign len_calc  = (32'(remaining) >= 32'(BURST_LEN)) ? LEN_W'(BURST_LEN) : LEN_W'(remaining);
   assign beat      = rd_valid && (outstanding != '0) && ((state == DATA) || (state == DRAIN));
   assign last_beat = beat && (outstanding == LEN_W'(1));
   assign push      = beat && (state == DATA) && !full;
   assign pop       = lcd_request && !empty;
   assign rd_req    = (state == REQ);

   sync_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .flush   (fs_evt),
      .push    (push),
      .wr_data (rd_data),
      .pop     (pop),
      .rd_data (fifo_q),
      .count   (count),
      .empty   (empty),
      .full    (full)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if ((remaining != '0) && !fs_evt && room) state_nxt = REQ;
         REQ:     if (rd_ack) state_nxt = (stale || fs_evt) ? DRAIN : DATA;
         DATA: begin
            if (last_beat)   state_nxt = IDLE;
            else if (fs_evt) state_nxt = DRAIN;
         end
         DRAIN:   if (last_beat) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fs_s        <= 1'b1;
         fs_d        <= 1'b1;
         next_addr   <= BASE;
         remaining   <= FRAME_WORDS;
         outstanding <= '0;
         stale       <= 1'b0;
         rd_addr     <= BASE;
         rd_len      <= '0;
      end else begin
         fs_s <= lcd_framesync;
         fs_d <= fs_s;
         // Request fields are latched so a frame reload cannot disturb a pending request.
         if ((state == IDLE) && (state_nxt == REQ)) begin
            rd_addr <= next_addr;
            rd_len  <= len_calc;
         end
         if ((state == REQ) && rd_ack) outstanding <= rd_len;
         else if (beat)                outstanding <= outstanding - 1'b1;
         if ((state != REQ) || rd_ack) stale <= 1'b0;
         else if (fs_evt)              stale <= 1'b1;
         if (fs_evt) begin
            next_addr <= BASE;
            remaining <= FRAME_WORDS;
         end else if ((state == REQ) && rd_ack && !stale) begin
            next_addr <= next_addr + ADDR_W'(rd_len);
            remaining <= remaining - REM_W'(rd_len);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         lcd_data  <= '0;
         underflow <= 1'b0;
      end else begin
         lcd_data <= pop ? fifo_q : '0;
         if (fs_evt)                    underflow <= 1'b0;
         else if (lcd_request && empty) underflow <= 1'b1;
      end
   end
endmodule

// File: tb/tb_lcd_frame_prefetch.sv
// tb/tb_lcd_frame_prefetch.sv - randomized self-checking bench against a queue-based frame model
module tb_lcd_frame_prefetch;
   localparam int DW    = 16;
   localparam int AW    = 8;
   localparam int HD    = 10;
   localparam int VD    = 5;
   localparam int BASE  = 250;
   localparam int BL    = 8;
   localparam int FD    = 32;
   localparam int TOTAL = HD * VD;
   localparam int AMOD  = 1 << AW;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          lcd_request = 1'b0;
   logic          lcd_framesync = 1'b1;
   logic [DW-1:0] lcd_data;
   logic          rd_req;
   logic [AW-1:0] rd_addr;
   logic [7:0]    rd_len;
   logic          rd_ack = 1'b0;
   logic          rd_valid = 1'b0;
   logic [DW-1:0] rd_data = '0;
   logic          underflow;

   always #5 clk = ~clk;

   lcd_frame_prefetch #(
      .DATA_W     (DW),
      .ADDR_W     (AW),
      .H_DISP     (HD),
      .V_DISP     (VD),
      .BASE_ADDR  (BASE),
      .BURST_LEN  (BL),
      .FIFO_DEPTH (FD)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .lcd_request   (lcd_request),
      .lcd_framesync (lcd_framesync),
      .lcd_data      (lcd_data),
      .rd_req        (rd_req),
      .rd_addr       (rd_addr),
      .rd_len        (rd_len),
      .rd_ack        (rd_ack),
      .rd_valid      (rd_valid),
      .rd_data       (rd_data),
      .underflow     (underflow)
   );

   int tests = 0;
   int fails = 0;

   int req_pct   = 0;
   int valid_pct = 100;
   int ack_max   = 0;
   bit ack_en    = 1'b1;

   logic [DW-1:0] q[$];
   int epoch      = 0;
   bit exp_uf     = 1'b0;
   int exp_addr   = BASE;
   int exp_rem    = TOTAL;
   bit req_seen   = 1'b0;
   int req_epoch  = 0;
   bit have_burst = 1'b0;
   int b_addr     = 0;
   int b_left     = 0;
   int b_epoch    = 0;
   int ack_wait   = 0;
   int fetched    = 0;
   int n_bursts   = 0;
   int last_len   = 0;
   int pops       = 0;
   int first_pop  = -1;
   int first_ack  = -1;
   int since_rst  = 0;
   bit first_req_pending = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
      end
   endtask

   // One clock of driver + SDRAM activity; fs marks the cycle in which the frame-start event acts.
   task automatic step(input bit fs);
      bit ack;
      bit val;
      bit req;
      int exp_d;
      int len_exp;
      int cur_burst;
      if (rd_req && !req_seen) begin
         req_seen  = 1'b1;
         req_epoch = epoch;
         if (first_req_pending) begin
            chk("first_req_latency", 32'(since_rst <= 2), 1);
            first_req_pending = 1'b0;
         end
         cur_burst = (have_burst && b_epoch == epoch) ? b_left : 0;
         chk("req_room", 32'((FD - q.size() - cur_burst) >= BL), 1);
      end
      ack = 1'b0;
      if (req_seen && ack_en && !have_burst) begin
         if (ack_wait == 0) ack = 1'b1;
         else               ack_wait--;
      end
      if (ack && req_epoch == epoch) begin
         len_exp = (exp_rem < BL) ? exp_rem : BL;
         chk("rd_addr", rd_addr, exp_addr);
         chk("rd_len", rd_len, len_exp);
      end
      val = have_burst && ($urandom_range(99) < valid_pct);
      req = ($urandom_range(99) < req_pct);
      lcd_request = req;
      rd_ack      = ack;
      rd_valid    = val;
      rd_data     = val ? DW'(b_addr) : '0;

      exp_d = 0;
      if (req) begin
         if (q.size() > 0) begin
            exp_d = q.pop_front();
            pops++;
            if (first_pop < 0) first_pop = exp_d;
         end else begin
            exp_uf = 1'b1;
         end
      end
      if (val) begin
         if (b_epoch == epoch) begin
            q.push_back(DW'(b_addr));
            chk("no_full_push", 32'(q.size() <= FD), 1);
         end
         b_addr = (b_addr + 1) % AMOD;
         b_left--;
         if (b_left == 0) have_burst = 1'b0;
      end
      if (fs) begin
         q.delete();
         epoch++;
         exp_uf    = 1'b0;
         exp_addr  = BASE;
         exp_rem   = TOTAL;
         first_pop = -1;
         first_ack = -1;
      end
      if (ack) begin
         have_burst = 1'b1;
         b_addr     = rd_addr;
         b_left     = rd_len;
         b_epoch    = req_epoch;
         req_seen   = 1'b0;
         ack_wait   = $urandom_range(ack_max);
         if (req_epoch == epoch) begin
            if (first_ack < 0) first_ack = rd_addr;
            exp_addr = (exp_addr + rd_len) % AMOD;
            exp_rem  = exp_rem - rd_len;
            fetched  = fetched + rd_len;
            n_bursts++;
            last_len = rd_len;
         end
      end

      @(posedge clk);
      #1;
      chk("lcd_data", lcd_data, exp_d);
      chk("underflow", underflow, exp_uf);
      chk("fifo_count", dut.u_fifo.count, q.size());
      since_rst++;
   endtask

   task automatic frame_sync();
      lcd_framesync = 1'b0;
      step(1'b0);
      step(1'b1);
      lcd_framesync = 1'b1;
   endtask

   task automatic do_reset();
      rst         = 1'b1;
      lcd_request = 1'b0;
      rd_ack      = 1'b0;
      rd_valid    = 1'b0;
      rd_data     = '0;
      @(posedge clk);
      #1;
      q.delete();
      epoch++;
      exp_uf    = 1'b0;
      exp_addr  = BASE;
      exp_rem   = TOTAL;
      req_seen  = 1'b0;
      ack_wait  = 0;
      fetched   = 0;
      n_bursts  = 0;
      pops      = 0;
      first_pop = -1;
      first_ack = -1;
      chk("rst_rd_req", rd_req, 0);
      chk("rst_rd_addr", rd_addr, BASE);
      chk("rst_rd_len", rd_len, 0);
      chk("rst_lcd_data", lcd_data, 0);
      chk("rst_underflow", underflow, 0);
      chk("rst_fifo_count", dut.u_fifo.count, 0);
      rst = 1'b0;
      since_rst = 0;
      first_req_pending = 1'b1;
   endtask

   initial begin
      // reset then prefill with no pixel demand: FIFO fills in whole bursts and stops
      do_reset();
      req_pct = 0; valid_pct = 100; ack_max = 0; ack_en = 1'b1;
      repeat (80) step(1'b0);
      chk("prefill_bursts", n_bursts, FD / BL);
      chk("prefill_words", q.size(), FD);
      chk("prefill_req_low", rd_req, 0);

      // full frame with random request, ack and beat spacing; addresses wrap past 2^AW
      req_pct = 30; valid_pct = 85; ack_max = 2;
      for (int i = 0; i < 3000 && pops < TOTAL; i++) step(1'b0);
      req_pct = 0;
      chk("frame_pops", pops, TOTAL);
      chk("frame_first_pixel", first_pop, BASE);
      repeat (30) step(1'b0);
      chk("frame_words", fetched, TOTAL);
      chk("burst_count", n_bursts, (TOTAL + BL - 1) / BL);
      chk("last_len", last_len, TOTAL % BL);
      chk("frame_req_low", rd_req, 0);
      chk("frame_no_underflow", underflow, 0);

      // memory stalled while the driver keeps requesting
      ack_en = 1'b0;
      frame_sync();
      req_pct = 100;
      repeat (40) step(1'b0);
      chk("uf_set", underflow, 1);
      chk("uf_data", lcd_data, 0);
      req_pct = 0;
      frame_sync();
      chk("uf_cleared", underflow, 0);
      ack_en = 1'b1;

      // frame sync after 3 beats of a burst: rest is drained, refetch restarts at base
      valid_pct = 100; ack_max = 0;
      for (int i = 0; i < 300 && !(have_burst && b_epoch == epoch && b_left == BL - 3); i++) step(1'b0);
      chk("mid_burst_reached", 32'(have_burst && b_epoch == epoch && b_left == BL - 3), 1);
      valid_pct = 0;
      frame_sync();
      valid_pct = 100; req_pct = 50;
      for (int i = 0; i < 300 && first_pop < 0; i++) step(1'b0);
      chk("fs_first_addr", first_ack, BASE);
      chk("fs_first_pixel", first_pop, BASE);

      // simultaneous push/pop, then reset with beats still owed
      req_pct = 100;
      for (int i = 0; i < 300 && !(have_burst && b_epoch == epoch && b_left == 4); i++) step(1'b0);
      chk("rst_burst_reached", 32'(have_burst && b_epoch == epoch && b_left == 4), 1);
      do_reset();
      ack_en = 1'b0; req_pct = 0;
      repeat (6) step(1'b0);
      chk("late_beats_ignored", dut.u_fifo.count, 0);
      chk("post_rst_req", rd_req, 1);
      chk("post_rst_addr", rd_addr, BASE);
      chk("post_rst_len", rd_len, BL);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/lcd_frame_prefetch.md
# lcd_frame_prefetch

Single-clock pixel prefetch stage directly upstream of the LCD timing driver. Issues burst reads to the SDRAM read port, buffers pixels in an on-chip FIFO, and returns one 16-bit pixel per driver data request. The driver raises its request one clock ahead of its display-enable window. This block therefore presents the pixel on the cycle after the request, which aligns it exactly with the display-enable window. Frame addressing restarts on each driver frame sync.

## Interface
- `DATA_W`, 16: pixel/SDRAM word width
- `ADDR_W`, 22: SDRAM word address width
- `H_DISP`, 480: active pixels per line
- `V_DISP`, 272: active lines per frame
- `BASE_ADDR`, 0: frame buffer start word address
- `BURST_LEN`, 64: maximum words per read burst (power of 2, ≤ FIFO_DEPTH/2)
- `FIFO_DEPTH`, 256: pixel FIFO depth (power of 2)

Ports:
- `clk`  in  1  system/pixel clock
- `rst`  in  1  reset, synchronous, active-high
- `lcd_request`  in  1  driver data request, one cycle ahead of display enable
- `lcd_framesync`  in  1  driver frame sync, active low
- `lcd_data`  out  DATA_W  pixel to driver
- `rd_req`  out  1  burst read request
- `rd_addr`  out  ADDR_W  burst start word address
- `rd_len`  out  8  burst length in words, 1..BURST_LEN
- `rd_ack`  in  1  request accepted
- `rd_valid`  in  1  read data beat valid
- `rd_data`  in  DATA_W  read data
- `underflow`  out  1  sticky: a request found the FIFO empty

## Operation
- Frame start event (`fs_evt`) is the registered falling edge of `lcd_framesync`: previous sample = 1 and current sample = 0.
- On `fs_evt`:
  - FIFO is flushed.
  - `next_addr` ← BASE_ADDR; `remaining` ← H_DISP·V_DISP.
  - `underflow` is cleared.
- FSM states:
  - **IDLE**: go to REQ when `remaining` > 0, `fs_evt` is not asserted, and `free` ≥ BURST_LEN.
    - `free` = FIFO_DEPTH − `count` − `outstanding`.
  - **REQ**: `rd_req` = 1. `rd_addr` = `next_addr`. `rd_len` = min(BURST_LEN, `remaining`).
    - All three are held stable until `rd_ack`.
    - On `rd_ack`: `outstanding` ← `rd_len`; `next_addr` += `rd_len`; `remaining` −= `rd_len`; go to DATA.
  - **DATA**: each `rd_valid` beat pushes `rd_data` and decrements `outstanding`.
    - Beats may be non-contiguous.
    - When `outstanding` reaches 0, go to IDLE.
  - **DRAIN**: entered when `fs_evt` occurs in DATA. Beats are counted but discarded. When `outstanding` reaches 0, go to IDLE.
  - `fs_evt` in REQ: hold the request until `rd_ack`, then go to DRAIN with `outstanding` = `rd_len`. The frame reload still happens at `fs_evt`. DRAIN discards exactly the accepted burst's beats.
  - `fs_evt` in IDLE: reload only.
- Pixel output:
  - `lcd_request` = 1 with FIFO non-empty: pop; `lcd_data` ← popped word on the next clock.
  - `lcd_request` = 1 with FIFO empty: `lcd_data` ← 0; `underflow` ← 1.
  - `lcd_request` = 0: `lcd_data` ← 0.
- Push and pop in the same cycle: `count` is unchanged. Push to a full FIFO cannot happen by construction; the bench asserts this.
- `rd_addr` wraps modulo 2^ADDR_W.
- `remaining` is wide enough for H_DISP·V_DISP (clog2 + 1).

## Timing
- Reset values:
  - `rd_req` = 0; `rd_addr` = BASE_ADDR; `rd_len` = 0; `lcd_data` = 0; `underflow` = 0.
  - FSM in IDLE.
  - FIFO empty; `outstanding` = 0.
  - `remaining` = H_DISP·V_DISP; `next_addr` = BASE_ADDR.
- Reset asserted mid-burst: all state returns to reset values. Beats that arrive later are ignored because `outstanding` = 0. The SDRAM side must be reset by the same `rst`.
- Request-to-data latency: 1 clock. `lcd_data` is registered; FIFO read is first-word-fall-through or registered-read, with the net latency still 1.
- `rd_req` rises at the earliest 1 clock after the IDLE condition holds.
- First `rd_req` after reset or `fs_evt`: within 2 clocks.
- `fs_evt` is detected 1 clock after the `lcd_framesync` falling edge. The FIFO is empty in the cycle following detection.

## Structure
- Shared package `lcd_pkg`:
  - Panel constants H_DISP and V_DISP, shared with the driver.
  - FSM state encoding IDLE/REQ/DATA/DRAIN.
  - `rd_len` width constant.
- Sub-module `sync_fifo`: DATA_W × FIFO_DEPTH, outputs `count`, `empty`, `full`, with synchronous `flush`.
  - Reusable by other single-clock stages.

## Test plan
- **Reset prefill**: reset, then `rd_ack` 1 cycle after each `rd_req` and contiguous data.
  - Requires bursts of 64 words at addresses 0, 64, 128, 192, then `rd_req` held low (free = 0).
- **Pixel order**: drive a full driver timing (480×272) with a memory model returning data = address.
  - Requires `lcd_data` = 0,1,2,… exactly 1 clock after each request.
  - Requires `underflow` = 0 and 130560 words fetched.
- **Last burst**: H_DISP = 5, V_DISP = 5, BURST_LEN = 8.
  - Requires bursts of length 8, 8, 8, 1, and no further `rd_req`.
- **Underflow**: stall `rd_ack` for 600 clocks while requests continue.
  - Requires `lcd_data` = 0 and `underflow` = 1, cleared at the next `fs_evt`.
- **Frame sync mid-burst**: `fs_evt` after 10 of 64 beats.
  - Requires the remaining 54 beats to be discarded and the next `rd_addr` = BASE_ADDR.
  - Requires the first popped pixel to come from BASE_ADDR.
- **Simultaneous push/pop and reset**: `rd_valid` with `lcd_request` every cycle, then `rst` mid-burst.
  - Requires `count` to be steady during push/pop.
  - After reset, requires all outputs at reset values and late beats ignored.
